expr_evaluator: RTL and testbench

//  Downstream of the expression syntax checker. Consumes the same ASCII character stream.

---
 rtl/expr_pkg.sv | 24 ++
 rtl/expr_char_class.sv | 23 ++
 rtl/expr_evaluator.sv | 197 +++++++++++++++++++
 tb/tb_expr_evaluator.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/expr_pkg.sv
// Shared definitions for the expression checker/evaluator family:
// character codes, FSM state encoding and character-class encoding.
package expr_pkg;

    localparam logic [7:0] CH_0   = 8'd48;
    localparam logic [7:0] CH_9   = 8'd57;
    localparam logic [7:0] CH_ADD = 8'd43;
    localparam logic [7:0] CH_MUL = 8'd42;

    typedef enum logic [1:0] {
        START = 2'd0,
        NUM   = 2'd1,
        OPR   = 2'd2,
        ERR   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        DIGIT   = 2'd0,
        OP_ADD  = 2'd1,
        OP_MUL  = 2'd2,
        ILLEGAL = 2'd3
    } cclass_t;

endpackage

// File: rtl/expr_char_class.sv
// Combinational ASCII decode into a character class and a 4-bit digit value.
module expr_char_class
    import expr_pkg::*;
(
    input  logic [7:0] i_char,
    output cclass_t    o_class_c,
    output logic [3:0] o_digit_c
);

    always_comb begin
        o_class_c = ILLEGAL;
        o_digit_c = 4'd0;
        if ((i_char >= CH_0) && (i_char <= CH_9)) begin
            o_class_c = DIGIT;
            o_digit_c = 4'(i_char - CH_0);
        end else if (i_char == CH_ADD) begin
            o_class_c = OP_ADD;
        end else if (i_char == CH_MUL) begin
            o_class_c = OP_MUL;
        end
    end

endmodule

// File: rtl/expr_evaluator.sv
// On-the-fly evaluator for '+'/'*' expressions over digit operands, '*' binding tighter.
// Define MULTIDIGIT_EN to let consecutive digits build a decimal operand.
module expr_evaluator
    import expr_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         restart,
    input  logic         in_valid,
    input  logic [7:0]   in,
    output logic [W-1:0] result,
    output logic         ok,
    output logic         err,
    output logic         ovf
);

    localparam int unsigned WW = 2 * W;
    localparam int unsigned WS = W + 1;

    state_t       r_state;
    logic [W-1:0] r_sum;
    logic [W-1:0] r_prod;
    logic [W-1:0] r_num;
    logic [W-1:0] r_result;
    logic         r_ok;
    logic         r_err;
    logic         r_ovf;

    state_t       w_state_next;
    logic [W-1:0] w_sum_next;
    logic [W-1:0] w_prod_next;
    logic [W-1:0] w_num_next;
    logic [W-1:0] w_result_next;
    logic         w_ovf_next;

    cclass_t      w_class;
    logic [3:0]   w_digit;

    expr_char_class u_char_class (
        .i_char    (in),
        .o_class_c (w_class),
        .o_digit_c (w_digit)
    );

    // Restart clears first; a char sampled on the same edge then applies to the fresh expression.
    state_t       w_st_b;
    logic [W-1:0] w_sum_b;
    logic [W-1:0] w_prod_b;
    logic [W-1:0] w_num_b;
    logic [W-1:0] w_result_b;
    logic         w_ovf_b;

    always_comb begin
        w_st_b     = r_state;
        w_sum_b    = r_sum;
        w_prod_b   = r_prod;
        w_num_b    = r_num;
        w_result_b = r_result;
        w_ovf_b    = r_ovf;
        if (restart) begin
            w_st_b     = START;
            w_sum_b    = '0;
            w_prod_b   = W'(1);
            w_num_b    = '0;
            w_result_b = '0;
            w_ovf_b    = 1'b0;
        end
    end

    // Operand after an accepted digit
    logic [W-1:0] w_num_dig;
    logic         w_dec_ovf;
`ifdef MULTIDIGIT_EN
    localparam int unsigned WD = W + 4;
    logic [WD-1:0] w_dec_wide;
    assign w_dec_wide = (WD'(w_num_b) * WD'(10)) + WD'(w_digit);
    assign w_num_dig  = w_dec_wide[W-1:0];
    assign w_dec_ovf  = |w_dec_wide[WD-1:W];
`else
    assign w_num_dig  = W'(w_digit);
    assign w_dec_ovf  = 1'b0;
`endif

    // Value of the prefix once the digit is folded in: sum + prod*num
    logic [WW-1:0] w_dprod_wide;
    logic [WS-1:0] w_dsum_wide;
    logic          w_dig_ovf;
    assign w_dprod_wide = WW'(w_prod_b) * WW'(w_num_dig);
    assign w_dsum_wide  = WS'(w_sum_b) + WS'(w_dprod_wide[W-1:0]);
    assign w_dig_ovf    = w_dec_ovf | (|w_dprod_wide[WW-1:W]) | w_dsum_wide[W];

    // Operator folding of the current operand into the accumulators
    logic [WW-1:0] w_oprod_wide;
    logic [WS-1:0] w_osum_wide;
    assign w_oprod_wide = WW'(w_prod_b) * WW'(w_num_b);
    assign w_osum_wide  = WS'(w_sum_b) + WS'(w_oprod_wide[W-1:0]);

    logic w_take_dig;
    logic w_take_add;
    logic w_take_mul;

    always_comb begin : fsm_next
        w_state_next = w_st_b;
        w_take_dig   = 1'b0;
        w_take_add   = 1'b0;
        w_take_mul   = 1'b0;
        if (in_valid) begin
            case (w_st_b)
                START, OPR: begin
                    if (w_class == DIGIT) begin
                        w_state_next = NUM;
                        w_take_dig   = 1'b1;
                    end else begin
                        w_state_next = ERR;
                    end
                end
                NUM: begin
                    case (w_class)
                        OP_ADD: begin
                            w_state_next = OPR;
                            w_take_add   = 1'b1;
                        end
                        OP_MUL: begin
                            w_state_next = OPR;
                            w_take_mul   = 1'b1;
                        end
`ifdef MULTIDIGIT_EN
                        DIGIT: begin
                            w_state_next = NUM;
                            w_take_dig   = 1'b1;
                        end
`endif
                        default: w_state_next = ERR;
                    endcase
                end
                default: w_state_next = ERR;
            endcase
        end
    end

    always_comb begin : dp_next
        w_sum_next    = w_sum_b;
        w_prod_next   = w_prod_b;
        w_num_next    = w_num_b;
        w_result_next = w_result_b;
        w_ovf_next    = w_ovf_b;
        if (w_take_dig) begin
            w_num_next    = w_num_dig;
            w_result_next = w_dsum_wide[W-1:0];
            w_ovf_next    = w_ovf_b | w_dig_ovf;
        end
        if (w_take_add) begin
            w_sum_next  = w_osum_wide[W-1:0];
            w_prod_next = W'(1);
            w_num_next  = '0;
            w_ovf_next  = w_ovf_b | (|w_oprod_wide[WW-1:W]) | w_osum_wide[W];
        end
        if (w_take_mul) begin
            w_prod_next = w_oprod_wide[W-1:0];
            w_num_next  = '0;
            w_ovf_next  = w_ovf_b | (|w_oprod_wide[WW-1:W]);
        end
        if (w_state_next == ERR) begin
            w_result_next = '0;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state  <= START;
            r_sum    <= '0;
            r_prod   <= W'(1);
            r_num    <= '0;
            r_result <= '0;
            r_ok     <= 1'b0;
            r_err    <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_sum    <= w_sum_next;
            r_prod   <= w_prod_next;
            r_num    <= w_num_next;
            r_result <= w_result_next;
            r_ok     <= (w_state_next == NUM);
            r_err    <= (w_state_next == ERR);
            r_ovf    <= w_ovf_next;
        end
    end

    assign result = r_result;
    assign ok     = r_ok;
    assign err    = r_err;
    assign ovf    = r_ovf;

endmodule

// File: tb/tb_expr_evaluator.sv
// Self-checking bench: W=16 and W=8 evaluators share one stream and are checked
// each cycle against a string-level reference that re-evaluates the accepted prefix.
module tb_expr_evaluator;

    logic        clk      = 1'b0;
    logic        clr_n    = 1'b1;
    logic        restart  = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_ch    = 8'd0;

    logic [15:0] res16;
    logic        ok16, err16, ovf16;
    logic [7:0]  res8;
    logic        ok8, err8, ovf8;

    always #5 clk = ~clk;

    expr_evaluator #(.W(16)) dut16 (
        .clk(clk), .clr_n(clr_n), .restart(restart), .in_valid(in_valid), .in(in_ch),
        .result(res16), .ok(ok16), .err(err16), .ovf(ovf16)
    );

    expr_evaluator #(.W(8)) dut8 (
        .clk(clk), .clr_n(clr_n), .restart(restart), .in_valid(in_valid), .in(in_ch),
        .result(res8), .ok(ok8), .err(err8), .ovf(ovf8)
    );

`ifdef MULTIDIGIT_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d at t=%0t", name, got, exp, $time);
        end
    endtask

    // Reference: accepted chars kept as a string, re-evaluated from scratch each time.
    byte unsigned q[$];
    bit           m_err;
    bit           m_ok;
    logic [15:0]  m_res[2];
    bit           m_ovf[2];

    function automatic bit is_dig(input byte unsigned c);
        return (c >= 8'd48) && (c <= 8'd57);
    endfunction

    function automatic bit is_op(input byte unsigned c);
        return (c == 8'd43) || (c == 8'd42);
    endfunction

    function automatic void m_clear();
        q.delete();
        m_err = 1'b0;
        m_ok  = 1'b0;
        m_res[0] = '0; m_res[1] = '0;
        m_ovf[0] = 1'b0; m_ovf[1] = 1'b0;
    endfunction

    function automatic bit legal_next(input byte unsigned c);
        if (is_dig(c)) begin
            if (q.size() == 0) return 1'b1;
            if (is_op(q[q.size()-1])) return 1'b1;
            return MD;
        end
        if (is_op(c)) return (q.size() != 0) && is_dig(q[q.size()-1]);
        return 1'b0;
    endfunction

    // Value of the prefix (sum of products) modulo 2^w, flagging any value that left w bits.
    function automatic void m_eval(input int unsigned w, output longint val, output bit ov);
        longint lim, total_v, term, opnd, t;
        lim = longint'(1) << w;
        total_v = 0; term = 1; opnd = 0; ov = 1'b0;
        foreach (q[i]) begin
            if (is_dig(q[i])) begin
                if (MD) opnd = opnd * 10 + longint'(q[i] - 8'd48);
                else    opnd = longint'(q[i] - 8'd48);
                if (opnd >= lim) begin ov = 1'b1; opnd = opnd % lim; end
            end else begin
                t = term * opnd;
                if (t >= lim) ov = 1'b1;
                t = t % lim;
                if (q[i] == 8'd43) begin
                    total_v = total_v + t;
                    if (total_v >= lim) ov = 1'b1;
                    total_v = total_v % lim;
                    term = 1;
                end else begin
                    term = t;
                end
                opnd = 0;
            end
        end
        t = term * opnd;
        if (t >= lim) ov = 1'b1;
        t = t % lim;
        val = total_v + t;
        if (val >= lim) ov = 1'b1;
        val = val % lim;
    endfunction

    function automatic void m_apply(input bit rs, input bit v, input byte unsigned c);
        longint val;
        bit     ov;
        if (rs) m_clear();
        if (!v || m_err) return;
        if (!legal_next(c)) begin
            m_err = 1'b1;
            m_ok  = 1'b0;
            m_res[0] = '0; m_res[1] = '0;
            return;
        end
        q.push_back(c);
        m_ok = is_dig(c);
        for (int k = 0; k < 2; k++) begin
            m_eval((k == 0) ? 16 : 8, val, ov);
            m_ovf[k] = m_ovf[k] | ov;
            if (m_ok) m_res[k] = 16'(val);
        end
    endfunction

    // Per-cycle comparison of both instances against the reference
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("res16", 32'(res16), 32'(m_res[0]));
            cmp("ok16",  32'(ok16),  32'(m_ok));
            cmp("err16", 32'(err16), 32'(m_err));
            cmp("ovf16", 32'(ovf16), 32'(m_ovf[0]));
            cmp("res8",  32'(res8),  32'(m_res[1]));
            cmp("ok8",   32'(ok8),   32'(m_ok));
            cmp("err8",  32'(err8),  32'(m_err));
            cmp("ovf8",  32'(ovf8),  32'(m_ovf[1]));
        end
    end

    task automatic step(input bit rs, input bit v, input byte unsigned c);
        @(negedge clk);
        restart  = rs;
        in_valid = v;
        in_ch    = c;
        @(posedge clk);
        m_apply(rs, v, c);
        #1;
    endtask

    task automatic send(input string s);
        for (int i = 0; i < s.len(); i++) step(1'b0, 1'b1, s[i]);
    endtask

    task automatic async_clear();
        @(negedge clk);
        restart  = 1'b0;
        in_valid = 1'b0;
        #2 clr_n = 1'b0;
        m_clear();
        #1;
        cmp("clr_res", 32'(res16), 32'd0);
        cmp("clr_ok",  32'(ok16),  32'd0);
        cmp("clr_err", 32'(err16), 32'd0);
        cmp("clr_ovf", 32'(ovf8),  32'd0);
        @(negedge clk);
        #2 clr_n = 1'b1;
    endtask

    initial begin
        string       s1;
        int          e1r[5];
        bit          e1o[5];
        byte unsigned c;
        bit          rs, v;
        int unsigned r;

        m_clear();
        #1 clr_n = 1'b0;
        #12;
        cmp("rst_res", 32'(res16), 32'd0);
        cmp("rst_ok",  32'(ok16),  32'd0);
        cmp("rst_err", 32'(err16), 32'd0);
        cmp("rst_ovf", 32'(ovf16), 32'd0);
        chk_en = 1'b1;
        @(negedge clk);
        #2 clr_n = 1'b1;

        // 1+2*3
        s1 = "1+2*3";
        e1r = '{1, 1, 3, 3, 7};
        e1o = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, s1[i]);
            cmp("t1_res", 32'(res16), 32'(e1r[i]));
            cmp("t1_ok",  32'(ok16),  32'(e1o[i]));
        end
        cmp("t1_err", 32'(err16), 32'd0);
        cmp("t1_ovf", 32'(ovf16), 32'd0);

        // 2*, idle, 4
        step(1'b1, 1'b0, 8'd0);
        send("2*");
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 8'h34);
            cmp("t2_hold_res", 32'(res16), 32'd2);
            cmp("t2_hold_ok",  32'(ok16),  32'd0);
        end
        send("4");
        cmp("t2_res", 32'(res16), 32'd8);
        cmp("t2_ok",  32'(ok16),  32'd1);

        // 1+a3, then restart with 5
        step(1'b1, 1'b0, 8'd0);
        send("1+a");
        cmp("t3_err_a", 32'(err16), 32'd1);
        cmp("t3_res_a", 32'(res16), 32'd0);
        send("3");
        cmp("t3_err_3", 32'(err16), 32'd1);
        cmp("t3_res_3", 32'(res16), 32'd0);
        cmp("t3_ok_3",  32'(ok16),  32'd0);
        step(1'b1, 1'b1, 8'h35);
        cmp("t3_rs_res", 32'(res16), 32'd5);
        cmp("t3_rs_ok",  32'(ok16),  32'd1);
        cmp("t3_rs_err", 32'(err16), 32'd0);

        // 9*9, async clear mid-cycle, then 5
        step(1'b1, 1'b0, 8'd0);
        send("9*9");
        cmp("t4_res", 32'(res16), 32'd81);
        async_clear();
        send("5");
        cmp("t4_after_res", 32'(res16), 32'd5);
        cmp("t4_after_ok",  32'(ok16),  32'd1);

        // 9*9*9 wraps at W=8
        step(1'b1, 1'b0, 8'd0);
        send("9*9*9");
        cmp("t5_res8",  32'(res8),  32'd217);
        cmp("t5_ovf8",  32'(ovf8),  32'd1);
        cmp("t5_ok8",   32'(ok8),   32'd1);
        cmp("t5_res16", 32'(res16), 32'd729);
        cmp("t5_ovf16", 32'(ovf16), 32'd0);
        send("+1");
        cmp("t5_res8b", 32'(res8), 32'd218);
        cmp("t5_ovf8b", 32'(ovf8), 32'd1);

        // 12+3
        step(1'b1, 1'b0, 8'd0);
        send("1");
        cmp("t6_res1", 32'(res16), 32'd1);
        send("2");
`ifdef MULTIDIGIT_EN
        cmp("t6_res12", 32'(res16), 32'd12);
        send("+");
        cmp("t6_resp", 32'(res16), 32'd12);
        send("3");
        cmp("t6_res15", 32'(res16), 32'd15);
        cmp("t6_ok",    32'(ok16),  32'd1);
`else
        cmp("t6_err", 32'(err16), 32'd1);
        cmp("t6_res", 32'(res16), 32'd0);
        send("+3");
        cmp("t6_err_held", 32'(err16), 32'd1);
`endif

        // Random stream
        step(1'b1, 1'b0, 8'd0);
        for (int n = 0; n < 4000; n++) begin
            r  = $urandom_range(0, 99);
            rs = ($urandom_range(0, 15) == 0);
            v  = ($urandom_range(0, 3) != 0);
            if (r < 50)      c = 8'(48 + $urandom_range(0, 9));
            else if (r < 70) c = 8'd43;
            else if (r < 90) c = 8'd42;
            else             c = 8'($urandom_range(0, 255));
            step(rs, v, c);
            if ($urandom_range(0, 299) == 0) async_clear();
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
